// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 bus receiver: command opcodes,
// byte-FSM state encoding and datapath widths.
package ili9341_pkg;

   // Datapath widths: window pointers are 16-bit, framebuffer address 17-bit.
   localparam int PTR_W  = 16;
   localparam int ADDR_W = 17;

   // Command opcodes understood by the decoder.
   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_SLPIN   = 8'h10;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPOFF = 8'h28;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

   // Byte FSM: what the next data byte means.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CASET_P,
      ST_PASET_P,
      ST_RAM_HI,
      ST_RAM_LO,
      ST_SKIP
   } rx_state_e;

endpackage

// File: rtl/ili9341_window_ctr.sv
// Window registers (SC/EC/SP/EP), column/page pointer, pointer advance and
// framebuffer address generation. Emits the registered write strobe.
module ili9341_window_ctr
   import ili9341_pkg::*;
#(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              clr_i,       // synchronous return to reset values
   input  logic              set_col_i,   // commit SC/EC from start_i/end_i
   input  logic              set_page_i,  // commit SP/EP from start_i/end_i
   input  logic [PTR_W-1:0]  start_i,
   input  logic [PTR_W-1:0]  end_i,
   input  logic              home_i,      // pointer <= (SC, SP)
   input  logic              pixel_i,     // a complete pixel was received
   output logic              fb_we_o,
   output logic [ADDR_W-1:0] fb_addr_o,
   output logic              frame_done_o
);

   localparam logic [PTR_W-1:0] EC_RST   = PTR_W'(WIDTH - 1);
   localparam logic [PTR_W-1:0] EP_RST   = PTR_W'(HEIGHT - 1);
   localparam logic [PTR_W-1:0] WIDTH_L  = PTR_W'(WIDTH);
   localparam logic [PTR_W-1:0] HEIGHT_L = PTR_W'(HEIGHT);

   logic [PTR_W-1:0]  sc_q, ec_q, sp_q, ep_q;
   logic [PTR_W-1:0]  col_q, page_q;
   logic              fb_we_q, frame_done_q;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic              win_ok, in_range, at_col_end, at_end;

   // An inverted window discards pixels and freezes the pointer.
   assign win_ok     = (sc_q <= ec_q) && (sp_q <= ep_q);
   assign in_range   = (col_q < WIDTH_L) && (page_q < HEIGHT_L);
   assign at_col_end = (col_q == ec_q);
   assign at_end     = at_col_end && (page_q == ep_q);
   // Exact for every on-panel pixel as long as WIDTH*HEIGHT fits in 17 bits.
   assign fb_addr_d  = ADDR_W'(page_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);

   // Window registers, pointer walk and registered write strobe.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sc_q         <= '0;
         ec_q         <= EC_RST;
         sp_q         <= '0;
         ep_q         <= EP_RST;
         col_q        <= '0;
         page_q       <= '0;
         fb_we_q      <= 1'b0;
         frame_done_q <= 1'b0;
         fb_addr_q    <= '0;
      end else if (clr_i) begin
         sc_q         <= '0;
         ec_q         <= EC_RST;
         sp_q         <= '0;
         ep_q         <= EP_RST;
         col_q        <= '0;
         page_q       <= '0;
         fb_we_q      <= 1'b0;
         frame_done_q <= 1'b0;
         fb_addr_q    <= '0;
      end else begin
         fb_we_q      <= 1'b0;
         frame_done_q <= 1'b0;
         if (set_col_i) begin
            sc_q <= start_i;
            ec_q <= end_i;
         end
         if (set_page_i) begin
            sp_q <= start_i;
            ep_q <= end_i;
         end
         if (home_i) begin
            col_q  <= sc_q;
            page_q <= sp_q;
         end
         if (pixel_i && win_ok) begin
            // Off-panel pixels still consume a pointer step.
            fb_we_q      <= in_range;
            frame_done_q <= in_range && at_end;
            if (in_range) begin
               fb_addr_q <= fb_addr_d;
            end
            if (at_col_end) begin
               col_q  <= sc_q;
               page_q <= (page_q == ep_q) ? sp_q : page_q + PTR_W'(1);
            end else begin
               col_q <= col_q + PTR_W'(1);
            end
         end
      end
   end

   assign fb_we_o      = fb_we_q;
   assign fb_addr_o    = fb_addr_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: rtl/ili9341_receiver.sv
// ILI9341 8-bit parallel bus receiver: detects byte strobes, decodes
// commands, collects window parameters and assembles RGB565 pixels that
// are written to a framebuffer through ili9341_window_ctr.
module ili9341_receiver
   import ili9341_pkg::*;
#(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              nreset,
   input  logic              cmd_data,
   input  logic              write_edge,
   input  logic [7:0]        din,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [15:0]       fb_data,
   output logic              frame_done,
   output logic              sleep_out,
   output logic              display_on
);

   rx_state_e        state_q;
   logic             edge_q;
   logic [1:0]       cnt_q;
   logic [23:0]      stage_q;
   logic [7:0]       hi_q;
   logic [15:0]      fb_data_q;
   logic             sleep_q, disp_q;

   logic             accept, is_cmd, is_data, soft_rst;
   logic             set_col, set_page, home, pixel;
   logic [PTR_W-1:0] win_start, win_end;

   // A byte is taken on the first cycle write_edge is seen high; panel reset blocks it.
   assign accept   = write_edge && !edge_q && nreset;
   assign is_cmd   = accept && !cmd_data;
   assign is_data  = accept && cmd_data;
   assign soft_rst = !nreset || (is_cmd && (din == CMD_SWRESET));

   // Window parameters commit on the 4th byte, using the staged first three.
   assign set_col   = is_data && (state_q == ST_CASET_P) && (cnt_q == 2'd3);
   assign set_page  = is_data && (state_q == ST_PASET_P) && (cnt_q == 2'd3);
   assign win_start = {stage_q[23:16], stage_q[15:8]};
   assign win_end   = {stage_q[7:0], din};
   assign home      = is_cmd && (din == CMD_RAMWR);
   assign pixel     = is_data && (state_q == ST_RAM_LO);

   // Registered copy of the byte strobe for edge detection.
   // NOTE: every clocked register here uses non-blocking assignment so all
   // flops update from the same pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         edge_q <= 1'b0;
      end else if (!nreset) begin
         edge_q <= 1'b0;
      end else begin
         // A soft-reset command must not re-trigger on its own held strobe.
         edge_q <= write_edge;
      end
   end

   // Command decode and byte FSM with registered status flags and pixel data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         stage_q   <= '0;
         hi_q      <= '0;
         fb_data_q <= '0;
         sleep_q   <= 1'b0;
         disp_q    <= 1'b0;
      end else if (soft_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         stage_q   <= '0;
         hi_q      <= '0;
         fb_data_q <= '0;
         sleep_q   <= 1'b0;
         disp_q    <= 1'b0;
      end else if (is_cmd) begin
         // Any command drops partial parameters and a pending high byte.
         cnt_q <= '0;
         hi_q  <= '0;
         case (din)
            CMD_SLPOUT: begin
               sleep_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            CMD_SLPIN: begin
               sleep_q <= 1'b0;
               state_q <= ST_IDLE;
            end
            CMD_DISPON: begin
               disp_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            CMD_DISPOFF: begin
               disp_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            CMD_CASET:  state_q <= ST_CASET_P;
            CMD_PASET:  state_q <= ST_PASET_P;
            CMD_RAMWR:  state_q <= ST_RAM_HI;
            CMD_RAMWRC: state_q <= ST_RAM_HI;
            default:    state_q <= ST_SKIP;
         endcase
      end else if (is_data) begin
         case (state_q)
            ST_CASET_P, ST_PASET_P: begin
               stage_q <= {stage_q[15:0], din};
               cnt_q   <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RAM_HI: begin
               hi_q    <= din;
               state_q <= ST_RAM_LO;
            end
            ST_RAM_LO: begin
               fb_data_q <= {hi_q, din};
               state_q   <= ST_RAM_HI;
            end
            default: ; // IDLE and SKIP ignore data bytes
         endcase
      end
   end

   ili9341_window_ctr #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT)
   ) u_window_ctr (
      .clk         (clk),
      .resetn      (resetn),
      .clr_i       (soft_rst),
      .set_col_i   (set_col),
      .set_page_i  (set_page),
      .start_i     (win_start),
      .end_i       (win_end),
      .home_i      (home),
      .pixel_i     (pixel),
      .fb_we_o     (fb_we),
      .fb_addr_o   (fb_addr),
      .frame_done_o(frame_done)
   );

   assign fb_data    = fb_data_q;
   assign sleep_out  = sleep_q;
   assign display_on = disp_q;

endmodule

// File: tb/tb_ili9341_receiver.sv
// Scoreboard bench for ili9341_receiver: stimulus pushes expected pixel
// writes, a negedge monitor pops and compares on every fb_we.
module tb_ili9341_receiver;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        nreset = 1'b1;
   logic        cmd_data = 1'b0;
   logic        write_edge = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        fb_we;
   logic [16:0] fb_addr;
   logic [15:0] fb_data;
   logic        frame_done;
   logic        sleep_out;
   logic        display_on;

   typedef struct packed {
      logic [16:0] addr;
      logic [15:0] data;
      logic        done;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   ili9341_receiver #(.WIDTH(320), .HEIGHT(240)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .nreset    (nreset),
      .cmd_data  (cmd_data),
      .write_edge(write_edge),
      .din       (din),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_data   (fb_data),
      .frame_done(frame_done),
      .sleep_out (sleep_out),
      .display_on(display_on)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Monitor: every write strobe must match the oldest expected pixel.
   exp_t e;
   always @(negedge clk) begin
      if (resetn) begin
         if (fb_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_fb_we", {31'b0, fb_we}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("fb_addr", {15'b0, fb_addr}, {15'b0, e.addr});
               check("fb_data", {16'b0, fb_data}, {16'b0, e.data});
               check("frame_done", {31'b0, frame_done}, {31'b0, e.done});
            end
         end else if (frame_done) begin
            check("frame_done_without_we", {31'b0, frame_done}, 32'd0);
         end
      end
   end

   task automatic send(input logic c, input logic [7:0] d);
      @(negedge clk);
      cmd_data   = c;
      din        = d;
      write_edge = 1'b1;
      @(negedge clk);
      write_edge = 1'b0;
      @(negedge clk);
   endtask

   task automatic cmd(input logic [7:0] d);
      send(1'b0, d);
   endtask

   task automatic dat(input logic [7:0] d);
      send(1'b1, d);
   endtask

   task automatic win4(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] x, input logic [7:0] y);
      cmd(c);
      dat(a); dat(b); dat(x); dat(y);
   endtask

   task automatic px(input logic [7:0] hi, input logic [7:0] lo, input logic we,
                     input logic [16:0] addr, input logic done);
      exp_t t;
      t.addr = addr;
      t.data = {hi, lo};
      t.done = done;
      if (we) exp_q.push_back(t);
      dat(hi);
      dat(lo);
   endtask

   task automatic panel_reset();
      @(negedge clk);
      nreset = 1'b0;
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      // Asynchronous reset values.
      repeat (3) @(negedge clk);
      check("rst_fb_we", {31'b0, fb_we}, 32'd0);
      check("rst_fb_addr", {15'b0, fb_addr}, 32'd0);
      check("rst_fb_data", {16'b0, fb_data}, 32'd0);
      check("rst_frame_done", {31'b0, frame_done}, 32'd0);
      check("rst_sleep_out", {31'b0, sleep_out}, 32'd0);
      check("rst_display_on", {31'b0, display_on}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Single pixel at origin.
      cmd(8'h2C);
      px(8'hF8, 8'h00, 1'b1, 17'd0, 1'b0);

      // 3x2 window at columns 10..12, pages 5..6, then wrap.
      panel_reset();
      win4(8'h2A, 8'h00, 8'd10, 8'h00, 8'd12);
      win4(8'h2B, 8'h00, 8'd5, 8'h00, 8'd6);
      cmd(8'h2C);
      px(8'h10, 8'h01, 1'b1, 17'd1610, 1'b0);
      px(8'h10, 8'h02, 1'b1, 17'd1611, 1'b0);
      px(8'h10, 8'h03, 1'b1, 17'd1612, 1'b0);
      px(8'h10, 8'h04, 1'b1, 17'd1930, 1'b0);
      px(8'h10, 8'h05, 1'b1, 17'd1931, 1'b0);
      px(8'h10, 8'h06, 1'b1, 17'd1932, 1'b1);
      px(8'h10, 8'h07, 1'b1, 17'd1610, 1'b0);

      // Pending high byte dropped by a command; RAMWRC keeps the pointer.
      panel_reset();
      cmd(8'h2C);
      dat(8'h12);
      cmd(8'h3C);
      px(8'hAB, 8'hCD, 1'b1, 17'd0, 1'b0);

      // Partial CASET leaves the window untouched.
      panel_reset();
      cmd(8'h2A);
      dat(8'h00); dat(8'h01); dat(8'h3F);
      cmd(8'h2C);
      px(8'h20, 8'h01, 1'b1, 17'd0, 1'b0);
      px(8'h20, 8'h02, 1'b1, 17'd1, 1'b0);

      // Window crossing the right edge: off-panel pixels skipped, pointer wraps.
      panel_reset();
      win4(8'h2A, 8'h01, 8'h3E, 8'h01, 8'h41);
      cmd(8'h2C);
      px(8'h30, 8'h01, 1'b1, 17'd318, 1'b0);
      px(8'h30, 8'h02, 1'b1, 17'd319, 1'b0);
      px(8'h30, 8'h03, 1'b0, 17'd0, 1'b0);
      px(8'h30, 8'h04, 1'b0, 17'd0, 1'b0);
      px(8'h30, 8'h05, 1'b1, 17'd638, 1'b0);

      // Inverted window discards pixels until a valid one is committed.
      panel_reset();
      win4(8'h2A, 8'h00, 8'd20, 8'h00, 8'd10);
      cmd(8'h2C);
      px(8'h40, 8'h01, 1'b0, 17'd0, 1'b0);
      px(8'h40, 8'h02, 1'b0, 17'd0, 1'b0);
      win4(8'h2A, 8'h00, 8'h00, 8'h00, 8'h01);
      win4(8'h2B, 8'h00, 8'h00, 8'h00, 8'h00);
      cmd(8'h2C);
      px(8'h40, 8'h03, 1'b1, 17'd0, 1'b0);
      px(8'h40, 8'h04, 1'b1, 17'd1, 1'b1);
      px(8'h40, 8'h05, 1'b1, 17'd0, 1'b0);

      // Strobe held high for 5 cycles: only the first byte counts.
      panel_reset();
      cmd(8'h2C);
      begin
         exp_t t;
         t.addr = 17'd0;
         t.data = 16'h1122;
         t.done = 1'b0;
         exp_q.push_back(t);
      end
      @(negedge clk);
      cmd_data   = 1'b1;
      din        = 8'h11;
      write_edge = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         din = din + 8'h33;
      end
      @(negedge clk);
      write_edge = 1'b0;
      @(negedge clk);
      dat(8'h22);

      // Status flags, panel reset and soft reset.
      cmd(8'h11);
      cmd(8'h29);
      check("sleep_out_set", {31'b0, sleep_out}, 32'd1);
      check("display_on_set", {31'b0, display_on}, 32'd1);
      panel_reset();
      check("sleep_out_nreset", {31'b0, sleep_out}, 32'd0);
      check("display_on_nreset", {31'b0, display_on}, 32'd0);
      cmd(8'h11);
      cmd(8'h29);
      cmd(8'h01);
      check("sleep_out_swreset", {31'b0, sleep_out}, 32'd0);
      check("display_on_swreset", {31'b0, display_on}, 32'd0);

      repeat (5) @(negedge clk);
      check("pending_expected", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
